dff_bank_arbiter: RTL and testbench

Round-robin write arbiter and sequencer for a shared W-bit register built from enable-gated D flip-flops. Up to N requesters compete for write access. The block grants one requester at a time, drives the register's enable and data for exactly one cycle, then pulses an acknowledge back to the winner. It sits between the requesting sequential lab blocks and the shared storage, and exposes the stored value and its complement.

---
 rtl/dff_bank_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
//
// Round-robin write arbiter and sequencer for a shared W-bit register built
// from enable-gated D flip-flops. One requester is granted at a time. The
// winner's data is presented to the storage with a single-cycle enable, and
// a single-cycle acknowledge is then pulsed back to the winner.
//
// Transaction timing (edge 0 is the edge where req is sampled in IDLE):
//   after edge 0 : gnt = onehot(winner), dff_en = 1, dff_d = winner data
//   after edge 1 : q = dff_d, ack = onehot(winner), gnt = 0, dff_en = 0
//   after edge 2 : ack = 0, busy = 0 (back in IDLE)
//
// Parameters:
//   N         number of requesters (2..8)
//   W         register width (1..32)
//   RESET_VAL value loaded into q on reset
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-low reset
//   req     per-requester write request, held until the matching ack
//   wdata   write data, slice i is wdata[i*W +: W]
//   gnt     one-hot grant, all zero when idle
//   ack     one-hot, one-cycle completion pulse to the granted requester
//   dff_en  storage write enable, one cycle per transaction
//   dff_d   data presented to storage, latched from the winner
//   q       stored register value
//   q_n     bitwise complement of q
//   busy    high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module dff_bank_arbiter #(
  parameter int             N         = 4,
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   wdata,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic             dff_en,
  output logic [W-1:0]     dff_d,
  output logic [W-1:0]     q,
  output logic [W-1:0]     q_n,
  output logic             busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t          state_reg,  state_next;
  logic [PW-1:0]   ptr_reg,    ptr_next;
  logic [PW-1:0]   sel_reg,    sel_next;
  logic [N-1:0]    gnt_reg,    gnt_next;
  logic [N-1:0]    ack_reg,    ack_next;
  logic            dff_en_reg, dff_en_next;
  logic [W-1:0]    dff_d_reg,  dff_d_next;
  logic [W-1:0]    q_reg,      q_next;
  logic            busy_reg,   busy_next;

  // Unpack the flat write-data bus into one slice per requester.
  logic [W-1:0] wdata_slice [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign wdata_slice[gi] = wdata[gi*W +: W];
    end
  endgenerate

  // Round-robin search: walk offsets from the far end back towards ptr so
  // that the last hit, i.e. the smallest offset from ptr, wins.
  logic            win_found;
  logic [PW-1:0]   win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_reg) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    sel_next    = sel_reg;
    gnt_next    = gnt_reg;
    ack_next    = ack_reg;
    dff_en_next = dff_en_reg;
    dff_d_next  = dff_d_reg;

    // The storage itself: a plain enable-gated D flip-flop bank.
    q_next = dff_en_reg ? dff_d_reg : q_reg;

    unique case (state_reg)
      IDLE: begin
        if (win_found) begin
          gnt_next          = '0;
          gnt_next[win_idx] = 1'b1;
          dff_d_next        = wdata_slice[win_idx];
          dff_en_next       = 1'b1;
          sel_next          = win_idx;
          state_next        = COMMIT;
        end
      end

      COMMIT: begin
        // q picks up dff_d on this edge through the enable path above.
        ack_next    = gnt_reg;
        gnt_next    = '0;
        dff_en_next = 1'b0;
        ptr_next    = (sel_reg == PW'(N - 1)) ? '0 : sel_reg + PW'(1);
        state_next  = ACK;
      end

      ACK: begin
        ack_next   = '0;
        state_next = IDLE;
      end

      default: begin
        gnt_next    = '0;
        ack_next    = '0;
        dff_en_next = 1'b0;
        state_next  = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      sel_reg    <= '0;
      gnt_reg    <= '0;
      ack_reg    <= '0;
      dff_en_reg <= 1'b0;
      dff_d_reg  <= '0;
      q_reg      <= RESET_VAL;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      sel_reg    <= sel_next;
      gnt_reg    <= gnt_next;
      ack_reg    <= ack_next;
      dff_en_reg <= dff_en_next;
      dff_d_reg  <= dff_d_next;
      q_reg      <= q_next;
      busy_reg   <= busy_next;
    end
  end

  assign gnt    = gnt_reg;
  assign ack    = ack_reg;
  assign dff_en = dff_en_reg;
  assign dff_d  = dff_d_reg;
  assign q      = q_reg;
  assign q_n    = ~q_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Self-checking bench for dff_bank_arbiter (N=4, W=8, RESET_VAL=0). A small
// reference model keeps the round-robin pointer and the stored value and
// derives each expected winner directly from the arbitration rule.
// -----------------------------------------------------------------------------
module tb_dff_bank_arbiter;

  localparam int           N  = 4;
  localparam int           W  = 8;
  localparam logic [W-1:0] RV = 8'h00;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic             dff_en;
  logic [W-1:0]     dff_d;
  logic [W-1:0]     q;
  logic [W-1:0]     q_n;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int           m_ptr = 0;
  logic [W-1:0] m_q   = RV;

  dff_bank_arbiter #(
    .N(N),
    .W(W),
    .RESET_VAL(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wdata(wdata),
    .gnt(gnt),
    .ack(ack),
    .dff_en(dff_en),
    .dff_d(dff_d),
    .q(q),
    .q_n(q_n),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester at or above m_ptr (wrapping) with its request set.
  function automatic int ref_winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // One full transaction. Inputs change on the falling edge; outputs are
  // sampled on the falling edge after each rising edge.
  task automatic run_txn(input logic [N-1:0] r, input logic [N*W-1:0] wd,
                         input bit drop, input string tag);
    int           w;
    logic [W-1:0] d;
    logic [N-1:0] oh;
    req   = r;
    wdata = wd;
    w     = ref_winner(r);
    d     = wd[w*W +: W];
    oh    = '0;
    oh[w] = 1'b1;

    @(posedge clk); @(negedge clk);
    checks++;
    if (gnt !== oh) begin
      errors++; $display("FAIL %s gnt_e0 got=%b exp=%b", tag, gnt, oh);
    end
    checks++;
    if (dff_en !== 1'b1 || busy !== 1'b1 || ack !== '0) begin
      errors++;
      $display("FAIL %s ctl_e0 got dff_en=%b busy=%b ack=%b exp 1 1 0000", tag, dff_en, busy, ack);
    end
    checks++;
    if (dff_d !== d) begin
      errors++; $display("FAIL %s dff_d got=%h exp=%h", tag, dff_d, d);
    end

    // Data changes after the sample edge must be ignored.
    wdata = $urandom;
    if (drop) req = '0;

    @(posedge clk); @(negedge clk);
    m_q   = d;
    m_ptr = (w + 1) % N;
    checks++;
    if (q !== m_q || q_n !== ~m_q) begin
      errors++; $display("FAIL %s q_e1 got q=%h q_n=%h exp q=%h q_n=%h", tag, q, q_n, m_q, ~m_q);
    end
    checks++;
    if (ack !== oh || gnt !== '0 || dff_en !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_e1 got ack=%b gnt=%b dff_en=%b exp ack=%b gnt=0000 dff_en=0", tag, ack, gnt, dff_en, oh);
    end

    @(posedge clk); @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b0 || q !== m_q) begin
      errors++;
      $display("FAIL %s end_e2 got ack=%b busy=%b q=%h exp ack=0000 busy=0 q=%h", tag, ack, busy, q, m_q);
    end
    $display("txn %s req=%b winner=%0d data=%h drop=%0d", tag, r, w, d, drop);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = '0;
    wdata = '0;
    #1;
    checks++;
    if (gnt !== '0 || ack !== '0 || dff_en !== 1'b0 || busy !== 1'b0 ||
        dff_d !== '0 || q !== RV || q_n !== ~RV) begin
      errors++;
      $display("FAIL reset_init got gnt=%b ack=%b en=%b busy=%b d=%h q=%h q_n=%h", gnt, ack, dff_en, busy, dff_d, q, q_n);
    end
    @(negedge clk) reset = 1'b1;

    // Reset in ACK with ack high: everything must clear without a clock edge.
    req   = 4'b0001;
    wdata = 32'h0000_0077;
    @(posedge clk); @(negedge clk);
    req = '0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || q !== 8'h77) begin
      errors++; $display("FAIL reset_pre got ack=%b q=%h exp ack=0001 q=77", ack, q);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || ack !== '0 || dff_en !== 1'b0 || busy !== 1'b0 ||
        q !== 8'h00 || q_n !== 8'hFF) begin
      errors++;
      $display("FAIL reset_async got gnt=%b ack=%b en=%b busy=%b q=%h q_n=%h", gnt, ack, dff_en, busy, q, q_n);
    end
    m_ptr = 0;
    m_q   = RV;
    @(negedge clk) reset = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_idle();
    req = '0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (gnt !== '0 || busy !== 1'b0 || dff_en !== 1'b0) begin
        errors++; $display("FAIL idle got gnt=%b busy=%b en=%b exp 0000 0 0", gnt, busy, dff_en);
      end
    end
  endtask

  task automatic test_full_contention();
    // Expected order 0,1,2,3,0 from ptr=0, values 11,22,33,44,11.
    for (int n = 0; n < 5; n++) begin
      run_txn(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, "contention");
    end
    checks++;
    if (m_q !== 8'h11 || q !== 8'h11) begin
      errors++; $display("FAIL contention_last got q=%h exp=11", q);
    end
    req = '0;
  endtask

  task automatic test_single_write();
    run_txn(4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00}, 1'b0, "single");
    checks++;
    if (q_n !== 8'h5A) begin
      errors++; $display("FAIL single_qn got=%h exp=5a", q_n);
    end
    req = '0;
  endtask

  task automatic test_wrap_around();
    run_txn(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b0, "wrap_setup");
    run_txn(4'b0101, {8'h00, 8'hC2, 8'h00, 8'h0A}, 1'b0, "wrap_first");
    checks++;
    if (q !== 8'h0A) begin
      errors++; $display("FAIL wrap_first_q got=%h exp=0a", q);
    end
    run_txn(4'b0101, {8'h00, 8'hC2, 8'h00, 8'h0A}, 1'b0, "wrap_second");
    checks++;
    if (q !== 8'hC2) begin
      errors++; $display("FAIL wrap_second_q got=%h exp=c2", q);
    end
    req = '0;
  endtask

  task automatic test_early_drop();
    run_txn(4'b1000, {8'h3C, 8'h00, 8'h00, 8'h00}, 1'b1, "early_drop");
    req = '0;
  endtask

  task automatic test_reset_mid();
    // Move ptr away from 0 first so a missing pointer reset is visible.
    run_txn(4'b0010, {8'h00, 8'h00, 8'h19, 8'h00}, 1'b0, "mid_setup");
    req   = 4'b1000;
    wdata = {8'hFF, 8'h00, 8'h00, 8'h00};
    @(posedge clk); @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++; $display("FAIL mid_gnt got=%b exp=1000", gnt);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (q !== RV || ack !== '0 || gnt !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got q=%h ack=%b gnt=%b busy=%b exp q=%h 0000 0000 0", q, ack, gnt, busy, RV);
    end
    m_ptr = 0;
    m_q   = RV;
    req   = '0;
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (ack !== '0 || q !== RV) begin
        errors++; $display("FAIL mid_noack got ack=%b q=%h exp ack=0000 q=%h", ack, q, RV);
      end
    end
    run_txn(4'b1010, {8'hEE, 8'h00, 8'h42, 8'h00}, 1'b0, "mid_after");
    req = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [N-1:0] r;
      r = N'($urandom_range(1, (1 << N) - 1));
      run_txn(r, $urandom, ($urandom_range(0, 3) == 0), "random");
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || q !== m_q) begin
          errors++; $display("FAIL random_gap got busy=%b gnt=%b q=%h exp 0 0000 %h", busy, gnt, q, m_q);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_contention();
    test_single_write();
    test_wrap_around();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
